// File: rtl/input_led_monitor_if.sv
// Board-input conditioner bus: raw inputs and controls in, debounced status and LED drive out.
interface input_led_monitor_if #(
  parameter int CHANNELS  = 6,
  parameter int CNT_WIDTH = 4
);
  logic [CHANNELS-1:0]  in;
  logic                 mode;
  logic                 count_clear;
  logic [CHANNELS-1:0]  stable;
  logic [CHANNELS-1:0]  rise;
  logic [CHANNELS-1:0]  led;
  logic                 any_active;
  logic [CNT_WIDTH-1:0] event_count;

  modport master (
    output in, mode, count_clear,
    input  stable, rise, led, any_active, event_count
  );

  modport slave (
    input  in, mode, count_clear,
    output stable, rise, led, any_active, event_count
  );
endinterface

// File: rtl/input_led_monitor.sv
// Multi-channel synchroniser/debouncer/edge detector driving board LEDs, with a
// shared wrapping counter of debounced rising edges.
module input_led_monitor #(
  parameter int CHANNELS        = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 4
) (
  input logic                clk,
  input logic                reset,
  input_led_monitor_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DLIM = DW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0]  sync_p0;
  logic [CHANNELS-1:0]  sync_p1;
  logic [DW-1:0]        dcnt [CHANNELS];
  logic [CHANNELS-1:0]  stable_p2;
  logic [CHANNELS-1:0]  rise_p2;
  logic [CHANNELS-1:0]  tog_p3;
  logic [CNT_WIDTH-1:0] count_p3;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [CHANNELS-1:0] v);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      n = n + CNT_WIDTH'(v[i]);
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
      rise_p2   <= '0;
      tog_p3    <= '0;
      count_p3  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      // p0/p1: two-flop synchroniser on the raw pins
      sync_p0 <= bus.in;
      sync_p1 <= sync_p0;

      // p2: debounce; the stable level moves only after DEBOUNCE_CYCLES straight mismatches
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          dcnt[i]    <= '0;
          rise_p2[i] <= 1'b0;
        end else if (dcnt[i] == DLIM) begin
          dcnt[i]      <= '0;
          stable_p2[i] <= sync_p1[i];
          rise_p2[i]   <= sync_p1[i];
        end else begin
          dcnt[i]    <= dcnt[i] + 1'b1;
          rise_p2[i] <= 1'b0;
        end
      end

      // p3: toggle state and event counter consume the rise pulses
      tog_p3 <= tog_p3 ^ rise_p2;
      if (bus.count_clear) begin
        count_p3 <= '0;
      end else begin
        count_p3 <= count_p3 + popcount(rise_p2);
      end
    end
  end

  assign bus.stable      = stable_p2;
  assign bus.rise        = rise_p2;
  assign bus.led         = bus.mode ? tog_p3 : stable_p2;
  assign bus.any_active  = |stable_p2;
  assign bus.event_count = count_p3;

endmodule

// File: tb/tb_input_led_monitor.sv
// Directed and randomised checks of input_led_monitor against a sample-window reference model.
module tb_input_led_monitor;

  localparam int CH = 6;
  localparam int D  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  input_led_monitor_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus ();

  input_led_monitor #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: stable flips once the last D synchronised samples all disagree with it.
  logic [CH-1:0] m_s1, m_s2, m_stable, m_rise, m_tog;
  logic [CH-1:0] m_hist [$];
  int            m_cnt;

  task automatic model_edge();
    logic [CH-1:0] flip;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_tog = '0; m_cnt = 0;
      m_hist = {};
      repeat (D) m_hist.push_back('0);
    end else begin
      m_hist.push_back(m_s2);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      flip = '1;
      foreach (m_hist[j]) flip = flip & (m_hist[j] ^ m_stable);
      m_tog = m_tog ^ m_rise;
      m_cnt = bus.count_clear ? 0 : (m_cnt + $countones(m_rise)) % (1 << CW);
      m_rise = flip & ~m_stable;
      m_stable = m_stable ^ flip;
      m_s2 = m_s1;
      m_s1 = bus.in;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] exp_led;
    exp_led = bus.mode ? m_tog : m_stable;
    check("stable", 32'(bus.stable), 32'(m_stable));
    check("rise", 32'(bus.rise), 32'(m_rise));
    check("led", 32'(bus.led), 32'(exp_led));
    check("any_active", 32'(bus.any_active), 32'(|m_stable));
    check("event_count", 32'(bus.event_count), 32'(m_cnt));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    logic [CH-1:0] v;
    bus.in = '0; bus.mode = 1'b0; bus.count_clear = 1'b0; reset = 1'b1;
    tick(1);

    // Reset held with all inputs high, then release
    bus.in = '1;
    tick(2);
    reset = 1'b0;
    tick(5);
    check("t1_hold", 32'(bus.stable), 32'h0);
    tick(1);
    check("t1_set", 32'(bus.stable), 32'h3f);
    bus.in = '0;
    tick(10);
    bus.count_clear = 1'b1;
    tick(1);
    bus.count_clear = 1'b0;

    // Single-channel debounce latency
    bus.in[0] = 1'b1;
    tick(5);
    check("t2_before", 32'(bus.stable[0]), 32'h0);
    tick(1);
    check("t2_stable", 32'(bus.stable[0]), 32'h1);
    check("t2_rise", 32'(bus.rise[0]), 32'h1);
    tick(1);
    check("t2_count", 32'(bus.event_count), 32'h1);
    check("t2_rise_off", 32'(bus.rise[0]), 32'h0);
    bus.in[0] = 1'b0;
    tick(8);

    // Glitch rejection, then a pulse just long enough
    bus.in[1] = 1'b1;
    tick(3);
    bus.in[1] = 1'b0;
    tick(8);
    check("t3_glitch", 32'(bus.event_count), 32'h1);
    bus.in[1] = 1'b1;
    tick(4);
    bus.in[1] = 1'b0;
    tick(10);
    check("t3_pulse", 32'(bus.event_count), 32'h2);

    // Simultaneous rises and counter wrap
    bus.count_clear = 1'b1;
    tick(1);
    bus.count_clear = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      bus.in = '1;
      tick(8);
      bus.in = '0;
      tick(8);
      check("t4_wrap", 32'(bus.event_count), 32'((6 * r) % 16));
    end

    // Toggle mode on channel 2
    bus.mode = 1'b1;
    for (int p = 0; p < 3; p++) begin
      bus.in[2] = 1'b1;
      tick(8);
      bus.in[2] = 1'b0;
      tick(8);
      check("t5_tog", 32'(bus.led[2]), 32'((p + 1) % 2));
    end
    bus.mode = 1'b0;
    #1;
    check("t5_mode_switch", 32'(bus.led[2]), 32'h0);
    check_all();

    // Clear in the same cycle as a rise pulse
    bus.in[4] = 1'b1;
    tick(6);
    check("t6_rise", 32'(bus.rise[4]), 32'h1);
    bus.count_clear = 1'b1;
    tick(1);
    bus.count_clear = 1'b0;
    check("t6_clear", 32'(bus.event_count), 32'h0);
    bus.in[4] = 1'b0;
    tick(8);

    // Reset partway through a debounce
    bus.in[3] = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("t6_reset", 32'(bus.stable), 32'h0);
    reset = 1'b0;
    bus.in = '0;
    tick(8);

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      v = bus.in;
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(5) == 0) v[ch] = ~v[ch];
      end
      bus.in = v;
      if ($urandom_range(19) == 0) bus.mode = ~bus.mode;
      bus.count_clear = ($urandom_range(39) == 0);
      reset = ($urandom_range(149) == 0);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_led_monitor.md
# input_led_monitor

Parametrised multi-channel input conditioner that drives the board LEDs. Each of `CHANNELS` asynchronous inputs (switches/buttons) is synchronised, debounced and edge-detected. Each LED shows either the stable input level or a per-channel toggle state. A shared counter accumulates debounced rising edges. The block sits between the board input pins and the LED and status logic of the top level, and supersedes the fixed six-LED single-input test block.

## Interface

Parameters:
- `CHANNELS`, 6, number of independent input/LED channels (≥1)
- `DEBOUNCE_CYCLES`, 4, consecutive cycles a synchronised input must differ from the stable value before the stable value updates (≥1)
- `CNT_WIDTH`, 4, width of `event_count`

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `in`  input  CHANNELS  raw asynchronous inputs
- `mode`  input  1  LED mode: 0 = follow stable level, 1 = toggle on each debounced rising edge
- `count_clear`  input  1  synchronous clear of `event_count`
- `stable`  output  CHANNELS  debounced level per channel (registered)
- `rise`  output  CHANNELS  one-cycle pulse per debounced 0→1 transition (registered)
- `led`  output  CHANNELS  LED drive: `stable` when `mode`=0, toggle state when `mode`=1
- `any_active`  output  1  OR-reduction of `stable`
- `event_count`  output  CNT_WIDTH  running count of debounced rising edges, all channels

## Operation

- Per channel, two-flop synchroniser: `s1 <= in[i]`, `s2 <= s1`.
- Debounce counter `dcnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - `s2 == stable[i]`: `dcnt <= 0`.
  - `s2 != stable[i]` and `dcnt < DEBOUNCE_CYCLES-1`: `dcnt <= dcnt+1`.
  - `s2 != stable[i]` and `dcnt == DEBOUNCE_CYCLES-1`: `stable[i] <= s2`, `dcnt <= 0` (update event).
- Any cycle with `s2 == stable` restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes `stable`.
- `rise[i] <= update_event[i] & s2[i]`. The pulse asserts on the same edge that `stable[i]` goes 1 and lasts exactly one cycle. Falling updates produce no pulse.
- Toggle state `tog[i]` flips on every edge where `rise[i]` is set. It is maintained regardless of `mode`.
- `led = mode ? tog : stable`. This output is combinational on `mode`, so a mode switch affects `led` in the same cycle.
- `event_count`:
  - `count_clear`=1: `event_count <= 0`. Clear takes priority, and pulses in that cycle are discarded.
  - Otherwise `event_count <= event_count + popcount(rise)`, truncated modulo 2^CNT_WIDTH (wraps, no saturation).
- Channels are fully independent. Simultaneous events on several channels are all honoured in the same cycle.

## Timing

- Reset (any cycle, including mid-debounce): on the next rising edge, `s1`, `s2`, `dcnt`, `stable`, `rise`, `tog` and `event_count` all become 0. Consequently `led`=0 and `any_active`=0.
- Reset has priority over every other input. Debounce in progress is abandoned.
- Latency: `in[i]` changes before edge k and then holds.
  - `s1` updates at edge k and `s2` at edge k+1.
  - `stable[i]` and `rise[i]` update at edge k+1+DEBOUNCE_CYCLES (k+5 at default).
  - `event_count` reflects the edge one edge later (k+6).
  - `led` (mode 0) and `any_active` follow `stable` combinationally.
- With `DEBOUNCE_CYCLES`=1, `stable` updates at edge k+2.
- `rise` is never high on two consecutive cycles for one channel. The minimum spacing is 2·DEBOUNCE_CYCLES cycles.

## Test plan

Defaults unless stated: CHANNELS=6, DEBOUNCE_CYCLES=4, CNT_WIDTH=4.

1. **Reset:** assert `reset` 2 cycles with `in`=6'b111111 → all outputs 0 throughout and on the first edge after release. `stable` stays 0 until 6 edges after release, since the synchroniser was cleared.
2. **Single-channel debounce:** `in[0]` 0→1 before edge 10, held → `stable[0]`, `led[0]`=1 and `rise[0]`=1 at edge 15 only; `event_count`=1 from edge 16; `any_active`=1 from edge 15.
3. **Glitch rejection:** `in[1]` high for 3 cycles then low → `stable[1]`, `rise[1]` and `event_count` unchanged. A 4-cycle-high pulse → `stable[1]` goes high for exactly 4 cycles, with one `rise[1]`.
4. **Simultaneous and wrap:** all 6 inputs rise together, then fall together, three times → each rising round adds 6 to `event_count`: 6, 12, then 18 mod 16 = 2.
5. **Toggle mode:** `mode`=1, two separate debounced presses on `in[2]` → `led[2]` goes 1 after the first rise and 0 after the second, while `stable[2]` follows the input. Switching `mode` to 0 shows `stable[2]` in the same cycle.
6. **Clear collision and mid-debounce reset:** assert `count_clear` in the same cycle as a `rise` → `event_count`=0. Assert `reset` when `dcnt`=2 → no `stable` change, and all state is 0.
